// File: rtl/multi_pkg.sv
// Shared types and helpers for the multi_seq shift-add multiplier.
package multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return (r == 0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/multi_addsh.sv
// One combinational add-shift step of the shift-add multiplier.
module multi_addsh #(
    parameter int unsigned PW = 16
) (
    input  logic [PW-1:0] i_acc,
    input  logic [PW-1:0] i_b,
    input  logic          i_a0,
    output logic [PW-1:0] o_acc_next,
    output logic [PW-1:0] o_b_next
);

    assign o_acc_next = i_a0 ? (i_acc + i_b) : i_acc;
    assign o_b_next   = {i_b[PW-2:0], 1'b0};

endmodule

// File: rtl/multi_seq.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/busy/done handshake.
// Define MULTI_SIGNED_EN to add the i_sgn port for two's-complement operands.
module multi_seq
    import multi_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_p1,
    input  logic [WIDTH-1:0]   i_p2,
`ifdef MULTI_SIGNED_EN
    input  logic               i_sgn,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int unsigned   PW       = 2 * WIDTH;
    localparam int unsigned   CW       = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e          r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [PW-1:0]    r_b, r_acc, r_result;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    w_acc_nxt, w_b_nxt, w_final;
    logic [WIDTH-1:0] w_a_ld, w_b_ld;
    logic             w_accept, w_last;

`ifdef MULTI_SIGNED_EN
    logic r_neg, w_neg_ld;

    // Operands are stored as magnitudes; -2^(WIDTH-1) still fits unsigned.
    always_comb begin
        w_a_ld   = (i_sgn && i_p1[WIDTH-1]) ? -i_p1 : i_p1;
        w_b_ld   = (i_sgn && i_p2[WIDTH-1]) ? -i_p2 : i_p2;
        w_neg_ld = i_sgn && (i_p1[WIDTH-1] ^ i_p2[WIDTH-1]);
    end

    assign w_final = r_neg ? -w_acc_nxt : w_acc_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_neg_ld;
        end
    end
`else
    assign w_a_ld  = i_p1;
    assign w_b_ld  = i_p2;
    assign w_final = w_acc_nxt;
`endif

    multi_addsh #(
        .PW(PW)
    ) u_addsh (
        .i_acc      (r_acc),
        .i_b        (r_b),
        .i_a0       (r_a[0]),
        .o_acc_next (w_acc_nxt),
        .o_b_next   (w_b_nxt)
    );

    assign w_accept = i_start && (r_state != ST_RUN);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= w_a_ld;
                r_b   <= {{WIDTH{1'b0}}, w_b_ld};
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= w_b_nxt;
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CW'(1);
                // The final step's add goes straight into the result register.
                if (w_last) r_result <= w_final;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: tb/tb_multi_seq.sv
// Self-checking bench for multi_seq: timeline model plus directed literal checks.
module tb_multi_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] p2 = '0;
    logic         sgn = 1'b0;
    logic         busy, done;
    logic [2*W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    multi_seq #(
        .WIDTH(W)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_p1     (p1),
        .i_p2     (p2),
`ifdef MULTI_SIGNED_EN
        .i_sgn    (sgn),
`endif
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: edges are numbered; a start accepted at edge k is busy after
    // edges k..k+W-1, publishes its product at edge k+W and shows done after it.
    longint unsigned e      = 0;
    longint unsigned m_acc  = 0;
    logic            m_have = 1'b0;
    logic [2*W-1:0]  m_pend = '0;
    logic [2*W-1:0]  m_res  = '0;

    function automatic logic [2*W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({56'd0, a});
            y = longint'({56'd0, b});
        end
        return 16'(x * y);
    endfunction

    function automatic logic busy_at(input longint unsigned edge_n);
        return m_have && edge_n >= m_acc && edge_n < m_acc + W;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e      = 0;
            m_have = 1'b0;
            m_res  = '0;
        end else begin
            logic was_busy;
            logic s_eff;
            was_busy = busy_at(e);
            e = e + 1;
            if (m_have && e == m_acc + W) m_res = m_pend;
`ifdef MULTI_SIGNED_EN
            s_eff = sgn;
`else
            s_eff = 1'b0;
`endif
            if (start && !was_busy) begin
                m_acc  = e;
                m_pend = product(p1, p2, s_eff);
                m_have = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", 32'(busy), 32'(busy_at(e)));
        chk("model_done", 32'(done), 32'(m_have && e == m_acc + W));
        chk("model_result", 32'(result), 32'(m_res));
    end

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
        @(posedge clk);
        #2;
        start = st;
        p1    = a;
        p2    = b;
        sgn   = s;
    endtask

    // Pulse start for one edge, wait (bounded) for done, check result and busy length.
    task automatic run_mul(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [2*W-1:0] exp, input int exp_busy);
        int nb;
        bit got;
        nb  = 0;
        got = 0;
        drive(1'b1, a, b, s);
        drive(1'b0, 8'hAA, 8'h55, s);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) got = 1;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_result"}, 32'(result), 32'(exp));
        if (exp_busy > 0) chk({nm, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        int t0, t1, nd;
        bit got;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        #1;
        rst = 1'b0;

        run_mul("mul_255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, W);
        run_mul("mul_0x173", 8'd0, 8'd173, 1'b0, 16'd0, W);
        run_mul("mul_3x5", 8'd3, 8'd5, 1'b0, 16'd15, W);

        // Start and operand changes during RUN must be ignored.
        drive(1'b1, 8'd12, 8'd10, 1'b0);
        drive(1'b0, 8'd12, 8'd10, 1'b0);
        drive(1'b0, 8'd12, 8'd10, 1'b0);
        drive(1'b1, 8'd99, 8'd77, 1'b0);
        drive(1'b0, 8'd1, 8'd2, 1'b0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("ignore_start_result", 32'(result), 32'd120);
            end
        end
        chk("ignore_start_done_count", nd, 1);

        // Asynchronous reset mid-RUN: outputs clear immediately, no done follows.
        drive(1'b1, 8'd100, 8'd3, 1'b0);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_result", 32'(result), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("async_rst_no_done", nd, 0);
        run_mul("after_rst_11x13", 8'd11, 8'd13, 1'b0, 16'd143, W);

        // Back-to-back: start held high, second start accepted in the DONE cycle.
        drive(1'b1, 8'd7, 8'd6, 1'b0);
        drive(1'b1, 8'd9, 8'd9, 1'b0);
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 40 && t1 < 0; i++) begin
            @(negedge clk);
            if (done) begin
                if (t0 < 0) begin
                    t0 = i;
                    chk("b2b_first_result", 32'(result), 32'd42);
                end else begin
                    t1 = i;
                    chk("b2b_second_result", 32'(result), 32'd81);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_seen", 32'(t0 >= 0), 32'd1);
        chk("b2b_spacing", t1 - t0, W + 1);
        repeat (3) @(negedge clk);

`ifdef MULTI_SIGNED_EN
        run_mul("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000, W);
        run_mul("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, W);
        run_mul("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001, W);
        run_mul("u_80x80", 8'h80, 8'h80, 1'b0, 16'h4000, W);
        run_mul("u_FDx5", 8'hFD, 8'h05, 1'b0, 16'h04F1, W);
`else
        run_mul("u_80x80", 8'h80, 8'h80, 1'b0, 16'h4000, W);
        run_mul("u_FDx5", 8'hFD, 8'h05, 1'b0, 16'h04F1, W);
`endif

        got = 0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_seq.md
# multi_seq

Parametrised sequential shift-add multiplier, the multi-cycle successor to the team's combinational 3-bit multiplier. It computes a WIDTH×WIDTH product one partial-product bit per clock, with a start/busy/done handshake. The result stays in a register until the next accepted start. It is a leaf arithmetic unit for datapaths where a WIDTH² adder array is too expensive.

## Interface
- WIDTH, 8, operand width in bits (≥2); the product is 2*WIDTH bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy==0.
- p1  input  WIDTH  multiplier operand; latched on the accepted start.
- p2  input  WIDTH  multiplicand operand; latched on the accepted start.
- sgn  input  1  1 = two's-complement operands; present only with MULTI_SIGNED_EN.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  2*WIDTH  product; held until the next accepted start completes.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: performs WIDTH iterations, tracked by cnt from 0 to WIDTH-1.
  - DONE: lasts one cycle, then returns to IDLE.
- Accepted start (busy==0, start==1, in IDLE or DONE):
  - latch a=p1 and b={WIDTH'b0,p2} into a 2*WIDTH-bit register;
  - clear acc and cnt;
  - enter RUN.
- Each RUN cycle:
  - if a[0], acc = acc + b (2*WIDTH-bit add, no overflow possible);
  - a = a>>1, b = b<<1, cnt = cnt+1.
- On the step with cnt==WIDTH-1:
  - load result with the final accumulator (including this step's add);
  - go to DONE.
- start while busy==1 is ignored; the operands are not re-latched.
- Changes on p1/p2 after acceptance have no effect.
- Zero operands still take the full WIDTH cycles; there is no early exit.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, acc=0, cnt=0.
- Reset mid-RUN aborts immediately. result returns to 0 and no done is issued.
- Start accepted at edge k:
  - busy=1 after edges k … k+WIDTH-1;
  - result updates at edge k+WIDTH;
  - done=1 and busy=0 for the cycle after edge k+WIDTH.
- Latency is WIDTH cycles from accepting edge to done.
- Back-to-back operation: start held high during the DONE cycle is accepted at edge k+WIDTH+1. Throughput is one product per WIDTH+1 cycles.
- During RUN, result keeps the previous product; it never shows partial sums.
- done and busy are never high together.

## Configuration
- Macro: MULTI_SIGNED_EN.
- Defined:
  - the sgn port exists.
  - With sgn=1 at acceptance:
    - store |p1| and |p2| (the magnitude of -2^(WIDTH-1) fits in WIDTH unsigned bits);
    - register neg = p1[MSB]^p2[MSB];
    - at the load into result, apply result = neg ? -acc : acc.
  - With sgn=0, behaviour is identical to unsigned.
  - Latency is unchanged.
- Not defined:
  - there is no sgn port;
  - operands are always unsigned;
  - there is no negation logic.

## Structure
- Package multi_pkg holds:
  - the state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - a function clog2 for sizing cnt.
- Sub-module multi_addsh: one combinational add-shift step.
  - Inputs: acc, b, a0.
  - Outputs: acc_next and b_next.
  - Instantiated once in RUN.
- The top level contains the FSM, counter, operand registers, sign handling and result register.

## Test plan
- WIDTH=8, p1=255, p2=255, start pulse at edge k → done at cycle k+9, result=16'hFE01; busy high exactly 8 cycles.
- p1=0, p2=173 → result=0 after the full 8 cycles; p1=3, p2=5 → 15.
- Start accepted with 12×10; p1/p2 changed and start pulsed during RUN → result=120, only one done.
- rst asserted at cycle 4 of RUN (asynchronous, mid-cycle) → outputs 0 immediately, no done; a new start afterwards gives the correct product.
- Start held high continuously with 7×6 then 9×9 → done pulses 9 cycles apart, results 42 then 81.
- With MULTI_SIGNED_EN and sgn=1:
  - -128×-128 → 16'h4000;
  - -3×5 → 16'hFFF1;
  - -1×-1 → 1.
  - With sgn=0, 8'h80×8'h80 → 16'h4000 and 8'hFD×5 → 16'h04F1.
